// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer driving a mac_4 accumulate unit: job in, operand stream, result out.
// Define MAC_SEQ_OVF_EN to add the shadow-sum overflow flag on res_ovf.
module mac_seq_ctrl #(
   parameter int N     = 4,
   parameter int ACC_W = 8,
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_a,
   input  logic [N-1:0]     in_b,
   output logic             mac_clr,
   output logic [N-1:0]     mac_a,
   output logic [N-1:0]     mac_b,
   input  logic [ACC_W-1:0] mac_acc,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [ACC_W-1:0] res_data,
   output logic             res_ovf
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [LEN_W-1:0]   r_rem;
   logic               r_drain;
   logic [N-1:0]       r_mac_a;
   logic [N-1:0]       r_mac_b;
   logic               r_res_valid;
   logic [ACC_W-1:0]   r_res_data;
   logic               w_beat;

   assign w_beat    = in_valid & (r_state == S_RUN);
   assign busy      = (r_state != S_IDLE);
   assign in_ready  = (r_state == S_RUN);
   assign mac_clr   = reset | (r_state == S_CLEAR);
   assign mac_a     = r_mac_a;
   assign mac_b     = r_mac_b;
   assign res_valid = r_res_valid;
   assign res_data  = r_res_data;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = (len != '0) ? S_CLEAR : S_DONE;
         S_CLEAR: w_next = S_RUN;
         S_RUN:   if (w_beat && r_rem == LEN_W'(1)) w_next = S_DRAIN;
         S_DRAIN: if (r_drain) w_next = S_DONE;
         S_DONE:  if (res_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_rem       <= '0;
         r_drain     <= 1'b0;
         r_mac_a     <= '0;
         r_mac_b     <= '0;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
      end else begin
         r_state <= w_next;
         // Operands default to zero so idle and gap cycles add nothing to the MAC.
         r_mac_a <= '0;
         r_mac_b <= '0;
         case (r_state)
            S_IDLE: begin
               if (start && len != '0) begin
                  r_rem <= len;
               end else if (start) begin
                  r_res_data  <= '0;
                  r_res_valid <= 1'b1;
               end
            end
            S_CLEAR: r_drain <= 1'b0;
            S_RUN: begin
               if (w_beat) begin
                  r_mac_a <= in_a;
                  r_mac_b <= in_b;
                  r_rem   <= r_rem - LEN_W'(1);
               end
            end
            S_DRAIN: begin
               r_drain <= ~r_drain;
               // Second drain edge: MAC has absorbed the last product.
               if (r_drain) begin
                  r_res_data  <= mac_acc;
                  r_res_valid <= 1'b1;
               end
            end
            S_DONE: if (res_ready) r_res_valid <= 1'b0;
            default: ;
         endcase
      end
   end

`ifdef MAC_SEQ_OVF_EN
   logic [ACC_W+LEN_W-1:0] r_shadow;
   logic [ACC_W-1:0]       w_prod;
   logic                   r_res_ovf;

   assign w_prod  = {{(ACC_W-N){1'b0}}, in_a} * {{(ACC_W-N){1'b0}}, in_b};
   assign res_ovf = r_res_ovf;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_shadow  <= '0;
         r_res_ovf <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE:  if (start && len == '0) r_res_ovf <= 1'b0;
            S_CLEAR: r_shadow <= '0;
            S_RUN:   if (w_beat) r_shadow <= r_shadow + {{LEN_W{1'b0}}, w_prod};
            S_DRAIN: if (r_drain) r_res_ovf <= |r_shadow[ACC_W+LEN_W-1:ACC_W];
            default: ;
         endcase
      end
   end
`else
   assign res_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl with a behavioural mac_4 accumulator on the MAC side.
module tb_mac_seq_ctrl;

   logic       clk = 1'b0;
   logic       reset, start, in_valid, res_ready;
   logic [3:0] len, in_a, in_b;
   logic       busy, in_ready, mac_clr, res_valid, res_ovf;
   logic [3:0] mac_a, mac_b;
   logic [7:0] mac_acc, res_data;

   int n_cmp = 0;
   int n_err = 0;
   logic [8:0] exp_q[$];

`ifdef MAC_SEQ_OVF_EN
   localparam logic OVF_450 = 1'b1;
`else
   localparam logic OVF_450 = 1'b0;
`endif

   always #5 clk = ~clk;

   mac_seq_ctrl #(.N(4), .ACC_W(8), .LEN_W(4)) dut (
      .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b), .mac_acc(mac_acc),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_ovf(res_ovf)
   );

   // mac_4 model: synchronous clear, otherwise accumulate A*B modulo 2^8.
   always @(posedge clk) begin
      if (mac_clr) mac_acc <= 8'd0;
      else         mac_acc <= mac_acc + ({4'd0, mac_a} * {4'd0, mac_b});
   end

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   // Monitor: each result handshake pops one expected {ovf,data}.
   always @(negedge clk) begin
      if (!reset && res_valid && res_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 32'(res_data), 32'hFFFF_FFFF);
         end else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            check("res_data", 32'(res_data), 32'(e[7:0]));
            check("res_ovf", 32'(res_ovf), 32'(e[8]));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input logic [3:0] l);
      start = 1'b1;
      len   = l;
      tick();
      start = 1'b0;
   endtask

   task automatic send_beat(input logic [3:0] a, input logic [3:0] b);
      bit done = 0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      for (int i = 0; i < 20 && !done; i++) begin
         if (in_ready) done = 1;
         tick();
      end
      if (!done) check("beat_timeout", 0, 1);
      in_valid = 1'b0;
      in_a     = '0;
      in_b     = '0;
   endtask

   task automatic wait_idle();
      bit done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         if (!busy) done = 1;
         else tick();
      end
      if (!done) check("idle_timeout", 0, 1);
   endtask

   task automatic wait_valid();
      bit done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         if (res_valid) done = 1;
         else tick();
      end
      if (!done) check("valid_timeout", 0, 1);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
      in_a = '0; in_b = '0; res_ready = 1'b1;
      tick(); tick();
      check("rst_mac_clr", 32'(mac_clr), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_res_valid", 32'(res_valid), 0);
      check("rst_res_data", 32'(res_data), 0);
      check("rst_res_ovf", 32'(res_ovf), 0);
      check("rst_mac_ab", 32'({mac_a, mac_b}), 0);
      check("rst_in_ready", 32'(in_ready), 0);
      reset = 1'b0;
      tick();

      // Job 1: single pair, latency check.
      exp_q.push_back({1'b0, 8'd6});
      start_job(4'd1);
      check("clear_mac_clr", 32'(mac_clr), 1);
      check("clear_in_ready", 32'(in_ready), 0);
      send_beat(4'd2, 4'd3);
      check("lat_k1_valid", 32'(res_valid), 0);
      tick();
      check("lat_k1b_valid", 32'(res_valid), 0);
      tick();
      check("lat_k2_valid", 32'(res_valid), 1);
      check("done_busy", 32'(busy), 1);
      tick();
      check("post_hs_busy", 32'(busy), 0);
      check("post_hs_valid", 32'(res_valid), 0);

      // Job 2: three pairs with a two-cycle source gap.
      exp_q.push_back({1'b0, 8'h5B});
      start_job(4'd3);
      tick();
      send_beat(4'd13, 4'd4);
      tick(); tick();
      send_beat(4'd7, 4'd3);
      send_beat(4'd3, 4'd6);
      check("drain_in_ready", 32'(in_ready), 0);
      wait_idle();
      tick();

      // Job 3: wrap past 2^8.
      exp_q.push_back({OVF_450, 8'd194});
      start_job(4'd2);
      tick();
      send_beat(4'd15, 4'd15);
      send_beat(4'd15, 4'd15);
      wait_idle();
      tick();

      // Job 4: result back-pressure with ignored start pulses.
      res_ready = 1'b0;
      start_job(4'd1);
      tick();
      send_beat(4'd6, 4'd7);
      wait_valid();
      for (int i = 0; i < 5; i++) begin
         start = 1'b1;
         len   = 4'd2;
         check("hold_res_data", 32'(res_data), 42);
         check("hold_res_valid", 32'(res_valid), 1);
         tick();
      end
      start = 1'b0;
      exp_q.push_back({1'b0, 8'd42});
      res_ready = 1'b1;
      wait_idle();
      tick();
      exp_q.push_back({1'b0, 8'd50});
      start_job(4'd1);
      tick();
      send_beat(4'd10, 4'd5);
      wait_idle();
      tick();

      // Job 5: reset one cycle after the first beat of a three-pair job.
      start_job(4'd3);
      tick();
      send_beat(4'd13, 4'd4);
      reset = 1'b1;
      #1;
      check("midrst_mac_clr", 32'(mac_clr), 1);
      tick();
      reset = 1'b0;
      check("midrst_busy", 32'(busy), 0);
      check("midrst_res_valid", 32'(res_valid), 0);
      tick(); tick();
      check("midrst_no_valid", 32'(res_valid), 0);
      exp_q.push_back({1'b0, 8'd50});
      start_job(4'd1);
      tick();
      send_beat(4'd10, 4'd5);
      wait_idle();
      tick();

      // Job 6: zero-length job.
      exp_q.push_back({1'b0, 8'd0});
      start_job(4'd0);
      check("zero_res_valid", 32'(res_valid), 1);
      check("zero_mac_clr", 32'(mac_clr), 0);
      check("zero_in_ready", 32'(in_ready), 0);
      tick();
      check("zero_mac_clr2", 32'(mac_clr), 0);
      check("zero_idle", 32'(busy), 0);
      tick(); tick();

      check("queue_empty", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
